// File: rtl/core_fetch_unit_pkg.sv
// Shared core types for the fetch stage: widths, reset PC and the fetch entry handed to decode.
package core_fetch_unit_pkg;

    localparam int PC_W   = 15;
    localparam int INST_W = 16;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 15'h0000;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Word-address increment; wraps from 15'h7FFF to 15'h0000.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/core_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory side plus the decode valid/ready handshake.
interface core_fetch_unit_if;
    import core_fetch_unit_pkg::*;

    logic [PC_W-1:0]   o_iAddr;
    logic              i_iIsBusy;
    logic [INST_W-1:0] i_iData;
    logic              i_halt;
    logic              i_jmpEn;
    logic [PC_W-1:0]   i_jmpAddr;
    logic              o_instVld;
    logic [INST_W-1:0] o_inst;
    logic [PC_W-1:0]   o_instPc;
    logic              i_instRdy;

    modport master (
        output o_iAddr, o_instVld, o_inst, o_instPc,
        input  i_iIsBusy, i_iData, i_halt, i_jmpEn, i_jmpAddr, i_instRdy
    );

    modport slave (
        input  o_iAddr, o_instVld, o_inst, o_instPc,
        output i_iIsBusy, i_iData, i_halt, i_jmpEn, i_jmpAddr, i_instRdy
    );

endinterface

// File: rtl/core_fetch_unit_fetch_buffer.sv
// In-order FIFO of fetch entries; flush wins over push and pop, storage is cleared on reset.
module fetch_buffer
    import core_fetch_unit_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(BUF_DEPTH);

    fetch_entry_t  mem [BUF_DEPTH];
    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Qualify requests so the FIFO can never over- or underflow.
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
    end

    assign dout  = mem[rptr_r];
    assign empty = (count_r == (AW+1)'(0));
    assign full  = (count_r == (AW+1)'(BUF_DEPTH));

    // Pointer, count and storage update.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (do_push_s) begin
                mem[wptr_r] <= din;
                wptr_r      <= wptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rptr_r <= rptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/core_fetch_unit.sv
// Instruction fetch stage: owns the PC, captures completed reads into a small FIFO for decode.
module core_fetch_unit
    import core_fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int              BUF_DEPTH = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    core_fetch_unit_if.master fetch
);

    logic [PC_W-1:0] pc_r;
    logic            cap_s;
    logic            pop_s;
    logic            buf_empty_s;
    logic            buf_full_s;
    fetch_entry_t    din_s;
    fetch_entry_t    dout_s;

    // A redirect discards the returned word and any concurrent pop.
    always_comb begin
        pop_s = fetch.o_instVld && fetch.i_instRdy && !fetch.i_jmpEn;
        cap_s = !fetch.i_iIsBusy && !fetch.i_halt && !fetch.i_jmpEn
                && (!buf_full_s || pop_s);
        din_s = '{pc: pc_r, inst: fetch.i_iData};
    end

    // Program counter: reset, then redirect, then advance on capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_r <= RESET_PC;
        end else if (fetch.i_jmpEn) begin
            pc_r <= fetch.i_jmpAddr;
        end else if (cap_s) begin
            pc_r <= pc_inc(pc_r);
        end else begin
            pc_r <= pc_r;
        end
    end

    fetch_buffer #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (cap_s),
        .pop   (pop_s),
        .flush (fetch.i_jmpEn),
        .din   (din_s),
        .dout  (dout_s),
        .empty (buf_empty_s),
        .full  (buf_full_s)
    );

    assign fetch.o_iAddr   = pc_r;
    assign fetch.o_instVld = !buf_empty_s;
    assign fetch.o_inst    = dout_s.inst;
    assign fetch.o_instPc  = dout_s.pc;

endmodule

// File: tb/tb_core_fetch_unit.sv
// Directed bench for core_fetch_unit: expected entries are queued by stimulus and popped by monitors.
module tb_core_fetch_unit;
    import core_fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rst_w;
    int   checks = 0;
    int   fails  = 0;

    fetch_entry_t exp_q[$];
    fetch_entry_t exp_w_q[$];
    fetch_entry_t got_e;
    fetch_entry_t got_w;

    core_fetch_unit_if f ();
    core_fetch_unit_if w ();

    core_fetch_unit dut (
        .i_clk (clk),
        .i_rst (rst),
        .fetch (f.master)
    );

    core_fetch_unit #(
        .RESET_PC (15'h7FFE)
    ) dut_wrap (
        .i_clk (clk),
        .i_rst (rst_w),
        .fetch (w.master)
    );

    always #5 clk = ~clk;

    // Memory model: the returned word is a fixed function of the address.
    assign f.i_iData = {1'b0, f.o_iAddr} ^ 16'hA5A5;
    assign w.i_iData = {1'b0, w.o_iAddr} ^ 16'hA5A5;

    function automatic fetch_entry_t mk(input logic [PC_W-1:0] pc);
        fetch_entry_t e;
        e.pc   = pc;
        e.inst = {1'b0, pc} ^ 16'hA5A5;
        return e;
    endfunction

    function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        f.i_iIsBusy = 1'b1;
        f.i_instRdy = 1'b0;
        f.i_halt    = 1'b0;
        f.i_jmpEn   = 1'b0;
        f.i_jmpAddr = 15'h0000;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    // Scoreboard for the default instance: compare on every accepted handshake.
    always @(negedge clk) begin
        if (!rst && f.o_instVld && f.i_instRdy && !f.i_jmpEn) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra_pop", {17'd0, f.o_instPc}, 32'hFFFF_FFFF);
            end else begin
                got_e = exp_q.pop_front();
                chk("sb_pc",   {17'd0, f.o_instPc}, {17'd0, got_e.pc});
                chk("sb_inst", {16'd0, f.o_inst},   {16'd0, got_e.inst});
            end
        end
    end

    // Scoreboard for the wrap instance.
    always @(negedge clk) begin
        if (!rst_w && w.o_instVld && w.i_instRdy && !w.i_jmpEn) begin
            if (exp_w_q.size() == 0) begin
                chk("sbw_extra_pop", {17'd0, w.o_instPc}, 32'hFFFF_FFFF);
            end else begin
                got_w = exp_w_q.pop_front();
                chk("sbw_pc",   {17'd0, w.o_instPc}, {17'd0, got_w.pc});
                chk("sbw_inst", {16'd0, w.o_inst},   {16'd0, got_w.inst});
            end
        end
    end

    initial begin
        rst_w       = 1'b1;
        w.i_iIsBusy = 1'b1;
        w.i_instRdy = 1'b0;
        w.i_halt    = 1'b0;
        w.i_jmpEn   = 1'b0;
        w.i_jmpAddr = 15'h0000;

        // Reset state
        do_reset();
        chk("rst_vld",  {31'd0, f.o_instVld}, 32'd0);
        chk("rst_addr", {17'd0, f.o_iAddr},   32'd0);
        chk("rst_inst", {16'd0, f.o_inst},    32'd0);
        chk("rst_pc",   {17'd0, f.o_instPc},  32'd0);

        // Streaming: one fetch per cycle, head PC one cycle behind o_iAddr
        for (int i = 0; i < 6; i++) exp_q.push_back(mk(15'(i)));
        f.i_iIsBusy = 1'b0;
        f.i_instRdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("stream_addr", {17'd0, f.o_iAddr}, i);
            cyc();
            chk("stream_vld", {31'd0, f.o_instVld}, 32'd1);
            chk("stream_pc",  {17'd0, f.o_instPc},  i);
        end
        f.i_iIsBusy = 1'b1;
        cyc();
        chk("stream_drained", {31'd0, f.o_instVld}, 32'd0);

        // Backpressure: buffer fills with PC 0,1 and the head stays stable
        do_reset();
        f.i_iIsBusy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_addr", {17'd0, f.o_iAddr}, (i + 1 < 2) ? i + 1 : 2);
            chk("bp_head", {17'd0, f.o_instPc}, 32'd0);
        end
        for (int i = 0; i < 5; i++) exp_q.push_back(mk(15'(i)));
        f.i_instRdy = 1'b1;
        cyc(3);
        f.i_iIsBusy = 1'b1;
        cyc(3);
        chk("bp_end_addr", {17'd0, f.o_iAddr},   32'd5);
        chk("bp_end_vld",  {31'd0, f.o_instVld}, 32'd0);

        // Interleaved busy: PC advances only on busy-low cycles
        do_reset();
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(15'(i)));
        f.i_instRdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            f.i_iIsBusy = (k % 2 == 1);
            chk("ilv_addr", {17'd0, f.o_iAddr}, (k + 1) / 2);
            cyc();
            chk("ilv_vld", {31'd0, f.o_instVld}, (k % 2 == 0) ? 32'd1 : 32'd0);
        end

        // Redirect with two entries buffered and a concurrent pop request
        do_reset();
        f.i_iIsBusy = 1'b0;
        cyc(2);
        chk("jmp_pre_addr", {17'd0, f.o_iAddr}, 32'd2);
        f.i_jmpEn   = 1'b1;
        f.i_jmpAddr = 15'h1234;
        f.i_instRdy = 1'b1;
        cyc();
        f.i_jmpEn = 1'b0;
        chk("jmp_vld",  {31'd0, f.o_instVld}, 32'd0);
        chk("jmp_addr", {17'd0, f.o_iAddr},   32'h1234);
        exp_q.push_back(mk(15'h1234));
        exp_q.push_back(mk(15'h1235));
        cyc();
        chk("jmp_first_pc", {17'd0, f.o_instPc}, 32'h1234);
        cyc();
        f.i_iIsBusy = 1'b1;
        cyc(2);
        chk("jmp_end_addr", {17'd0, f.o_iAddr},   32'h1236);
        chk("jmp_end_vld",  {31'd0, f.o_instVld}, 32'd0);

        // Mid-operation reset with a full buffer and a redirect pending
        do_reset();
        f.i_iIsBusy = 1'b0;
        cyc(2);
        rst         = 1'b1;
        f.i_jmpEn   = 1'b1;
        f.i_jmpAddr = 15'h0555;
        cyc();
        rst         = 1'b0;
        f.i_jmpEn   = 1'b0;
        f.i_iIsBusy = 1'b1;
        chk("mrst_vld",  {31'd0, f.o_instVld}, 32'd0);
        chk("mrst_addr", {17'd0, f.o_iAddr},   32'd0);
        chk("mrst_inst", {16'd0, f.o_inst},    32'd0);

        // Wrap and halt on the RESET_PC=7FFE instance
        cyc();
        rst_w = 1'b0;
        chk("w_rst_addr", {17'd0, w.o_iAddr},   32'h7FFE);
        chk("w_rst_vld",  {31'd0, w.o_instVld}, 32'd0);
        exp_w_q.push_back(mk(15'h7FFE));
        exp_w_q.push_back(mk(15'h7FFF));
        exp_w_q.push_back(mk(15'h0000));
        w.i_iIsBusy = 1'b0;
        w.i_instRdy = 1'b1;
        chk("w_addr0", {17'd0, w.o_iAddr}, 32'h7FFE);
        cyc();
        chk("w_addr1", {17'd0, w.o_iAddr}, 32'h7FFF);
        cyc();
        chk("w_addr2", {17'd0, w.o_iAddr}, 32'h0000);
        cyc();
        w.i_halt = 1'b1;
        cyc();
        chk("w_halt_addr", {17'd0, w.o_iAddr}, 32'h0001);
        cyc();
        chk("w_halt_addr2", {17'd0, w.o_iAddr},   32'h0001);
        chk("w_halt_vld",   {31'd0, w.o_instVld}, 32'd0);

        chk("sb_q_empty",  exp_q.size(),   32'd0);
        chk("sbw_q_empty", exp_w_q.size(), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
